// File: rtl/sha1_padder.sv
// sha1_padder: byte-stream front end for the sha1 core.
// Collects message bytes into a 512-bit block, appends 0x80, zero fill and
// the 64-bit big-endian bit length, and presents each block over a
// valid/ready handshake. Byte 0 of a block sits at block_out[511:504].
// Optional feature macro: SHA1_PADDER_BLKCNT_EN adds a saturating
// emitted-block counter on block_count.
module sha1_padder (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [511:0] block_out,
   output logic         block_valid,
   output logic         block_last,
   input  logic         block_ready
`ifdef SHA1_PADDER_BLKCNT_EN
   ,
   output logic [15:0]  block_count
`endif
);

   typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_LENBLK} state_t;

   state_t         state_q;
   logic [511:0]   buf_q;
   logic [6:0]     pos_q;
   logic [63:0]    len_q;
   logic           pad_pend_q;
   logic           valid_q;
   logic           last_q;

   logic [511:0]   fill_buf_d;
   logic [511:0]   pad_buf_d;

   // Buffer images: current byte written at pos, and the 0x80/zero/length
   // padding applied from pos onward.
   always_comb begin
      fill_buf_d = buf_q;
      pad_buf_d  = buf_q;
      for (int b = 0; b < 64; b++) begin
         if (pos_q == 7'(b)) begin
            fill_buf_d[511-8*b -: 8] = in_data;
            pad_buf_d[511-8*b -: 8]  = 8'h80;
         end else if (pos_q < 7'(b)) begin
            pad_buf_d[511-8*b -: 8]  = 8'h00;
         end
      end
      // Length fits behind the 0x80 only if the marker lands at byte 55 or lower.
      if (pos_q <= 7'd55) pad_buf_d[63:0] = len_q;
   end

   // Main FSM: fill, pad, emit and length-only block generation.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_FILL;
         buf_q      <= '0;
         pos_q      <= '0;
         len_q      <= '0;
         pad_pend_q <= 1'b0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state_q)
            S_FILL: begin
               if (in_valid) begin
                  buf_q <= fill_buf_d;
                  pos_q <= pos_q + 7'd1;
                  len_q <= len_q + 64'd8;
                  if (pos_q == 7'd63) begin
                     // Block full: emit it now; a final byte here still owes padding.
                     state_q    <= S_EMIT;
                     valid_q    <= 1'b1;
                     last_q     <= 1'b0;
                     pad_pend_q <= in_last;
                  end else if (in_last) begin
                     state_q <= S_PAD;
                  end
               end
            end
            S_PAD: begin
               buf_q   <= pad_buf_d;
               valid_q <= 1'b1;
               state_q <= S_EMIT;
               if (pos_q <= 7'd55) begin
                  last_q <= 1'b1;
               end else begin
                  last_q     <= 1'b0;
                  pad_pend_q <= 1'b1;
               end
            end
            S_EMIT: begin
               if (block_ready) begin
                  valid_q <= 1'b0;
                  buf_q   <= '0;
                  if (last_q) begin
                     last_q  <= 1'b0;
                     pos_q   <= '0;
                     len_q   <= '0;
                     state_q <= S_FILL;
                  end else if (pad_pend_q) begin
                     pad_pend_q <= 1'b0;
                     // pos==64 means the data ended exactly on a block boundary,
                     // so the next block starts with the 0x80 marker.
                     if (pos_q == 7'd64) begin
                        pos_q   <= '0;
                        state_q <= S_PAD;
                     end else begin
                        state_q <= S_LENBLK;
                     end
                  end else begin
                     pos_q   <= '0;
                     state_q <= S_FILL;
                  end
               end
            end
            S_LENBLK: begin
               buf_q   <= {448'h0, len_q};
               last_q  <= 1'b1;
               valid_q <= 1'b1;
               state_q <= S_EMIT;
            end
            default: state_q <= S_FILL;
         endcase
      end
   end

   assign in_ready    = reset & (state_q == S_FILL);
   assign block_out   = buf_q;
   assign block_valid = valid_q;
   assign block_last  = last_q;

`ifdef SHA1_PADDER_BLKCNT_EN
   logic [15:0] cnt_q;

   // Saturating count of accepted blocks; only reset clears it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (valid_q && block_ready && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign block_count = cnt_q;
`endif

endmodule
